// File: rtl/pc_predict.sv
// Fetch-stage next-PC predictor with a speculative return-address stack and
// a D/E/M checkpoint chain that lets a mispredicted jump roll the stack back.
module pc_predict #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [3:0]               f_icode_i,
    input  logic [63:0]              f_valC_i,
    input  logic [63:0]              f_valP_i,
    input  logic                     F_stall_i,
    input  logic                     D_stall_i,
    input  logic                     D_bubble_i,
    input  logic                     E_bubble_i,
    input  logic                     M_bubble_i,
    input  logic [3:0]               M_icode_i,
    input  logic                     M_Cnd_i,
    output logic [63:0]              F_predPC_o,
    output logic [$clog2(DEPTH):0]   ras_count_o,
    output logic                     ras_empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [3:0] IJXX  = 4'h7;
    localparam logic [3:0] ICALL = 4'h8;
    localparam logic [3:0] IRET  = 4'h9;

    typedef struct packed {
        logic          valid;
        logic [PW-1:0] ptr;
        logic [CW-1:0] count;
    } ckpt_t;

    logic [63:0]   stack [DEPTH];
    logic [63:0]   pred_pc;
    logic [PW-1:0] ptr;
    logic [CW-1:0] count;
    ckpt_t         d_ck, e_ck, m_ck;

    logic          mis;
    logic [PW-1:0] eff_ptr, ret_ptr, nxt_ptr;
    logic [CW-1:0] eff_count, nxt_count;
    logic [63:0]   nxt_pc;
    logic          push;
    ckpt_t         f_snap;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mis       = (M_icode_i == IJXX) && !M_Cnd_i && !M_bubble_i;
        eff_ptr   = ptr;
        eff_count = count;
        if (mis && m_ck.valid) begin
            eff_ptr   = m_ck.ptr;
            eff_count = m_ck.count;
        end
        ret_ptr   = eff_ptr - PW'(1);
        f_snap    = '{valid: 1'b1, ptr: eff_ptr, count: eff_count};

        nxt_ptr   = eff_ptr;
        nxt_count = eff_count;
        nxt_pc    = pred_pc;
        push      = 1'b0;
        if (!F_stall_i) begin
            nxt_pc = f_valP_i;
            case (f_icode_i)
                IJXX: nxt_pc = f_valC_i;
                ICALL: begin
                    push    = 1'b1;
                    nxt_pc  = f_valC_i;
                    nxt_ptr = eff_ptr + PW'(1);
                    // A full stack overwrites its oldest entry; count saturates.
                    if (eff_count != CW'(DEPTH))
                        nxt_count = eff_count + CW'(1);
                end
                IRET: begin
                    if (eff_count != '0) begin
                        nxt_pc    = stack[ret_ptr];
                        nxt_ptr   = ret_ptr;
                        nxt_count = eff_count - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pred_pc <= RESET_PC;
            ptr     <= '0;
            count   <= '0;
            d_ck    <= '0;
            e_ck    <= '0;
            m_ck    <= '0;
        end else begin
            pred_pc <= nxt_pc;
            ptr     <= nxt_ptr;
            count   <= nxt_count;
            if (!D_stall_i)
                d_ck <= (D_bubble_i || F_stall_i) ? '0 : f_snap;
            e_ck <= E_bubble_i ? '0 : d_ck;
            m_ck <= M_bubble_i ? '0 : e_ck;
        end
    end

    // NOTE: the stack array is not reset; count==0 already marks every entry as unused.
    always_ff @(posedge clk_i) begin
        if (push)
            stack[eff_ptr] <= f_valP_i;
    end

    assign F_predPC_o  = pred_pc;
    assign ras_count_o = count;
    assign ras_empty_o = (count == '0);

endmodule
